// File: rtl/mem_access_unit.sv
// Load/store unit between the decode/execute register and the data-memory bus.
// One operation in flight; holds upstream stages via stall_out while busy.
module mem_access_unit #(
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        is_load_in,
    input  logic        is_store_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [4:0]  rd_addr_in,
    output logic        stall_out,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        lu_valid_out,
    output logic [31:0] lu_output_out,
    output logic [4:0]  lu_rd_addr_out,
    output logic        misaligned_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic        r_lu_valid;
    logic [31:0] r_lu_output;
    logic [4:0]  r_lu_rd;
    logic        r_misal;

    logic        w_is_mem;
    logic        w_aligned_raw;
    logic        w_start;
    logic        w_misal;
    logic        w_is_store;
    logic        w_in_req;
    logic [3:0]  w_strb_next;
    logic [31:0] w_wdata_next;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_fmt;

    assign w_is_mem   = valid_in & (is_load_in | is_store_in);
    assign w_is_store = is_store_in & ~is_load_in;

    always_comb begin
        w_aligned_raw = 1'b1;
        case (load_size_in)
            2'b00:   w_aligned_raw = 1'b1;
            2'b01:   w_aligned_raw = ~addr_in[0];
            default: w_aligned_raw = (addr_in[1:0] == 2'b00);
        endcase
    end

    // With ALIGN_CHECK off every access proceeds and the low address bits are ignored by lane logic.
    assign w_misal = ALIGN_CHECK && (r_state == IDLE) && w_is_mem && !w_aligned_raw;
    assign w_start = (r_state == IDLE) && w_is_mem && (!ALIGN_CHECK || w_aligned_raw);

    always_comb begin
        w_strb_next  = 4'b1111;
        w_wdata_next = store_data_in;
        case (load_size_in)
            2'b00: begin
                w_strb_next  = 4'b0001 << addr_in[1:0];
                w_wdata_next = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                w_strb_next  = 4'b0011 << {addr_in[1], 1'b0};
                w_wdata_next = {2{store_data_in[15:0]}};
            end
            default: begin
                w_strb_next  = 4'b1111;
                w_wdata_next = store_data_in;
            end
        endcase
    end

    always_comb begin
        w_ld_byte = dmem_rdata[7:0];
        case (r_lane)
            2'd0:    w_ld_byte = dmem_rdata[7:0];
            2'd1:    w_ld_byte = dmem_rdata[15:8];
            2'd2:    w_ld_byte = dmem_rdata[23:16];
            default: w_ld_byte = dmem_rdata[31:24];
        endcase
        w_ld_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_size)
            2'b00:   w_ld_fmt = {{24{~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_fmt = {{16{~r_unsigned & w_ld_half[15]}}, w_ld_half};
            default: w_ld_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= RESET_ADDR;
            r_we        <= 1'b0;
            r_wstrb     <= 4'b0000;
            r_wdata     <= 32'h0;
            r_lane      <= 2'b00;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_rd        <= 5'd0;
            r_lu_valid  <= 1'b0;
            r_lu_output <= 32'h0;
            r_lu_rd     <= 5'd0;
            r_misal     <= 1'b0;
        end else begin
            r_lu_valid <= 1'b0;
            r_misal    <= w_misal;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_addr     <= {addr_in[31:2], 2'b00};
                        r_we       <= w_is_store;
                        r_wstrb    <= w_is_store ? w_strb_next : 4'b0000;
                        r_wdata    <= w_is_store ? w_wdata_next : 32'h0;
                        r_lane     <= addr_in[1:0];
                        r_size     <= load_size_in;
                        r_unsigned <= load_unsigned_in;
                        r_rd       <= rd_addr_in;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    // Stores are posted: no response is expected.
                    if (dmem_req_ready) r_state <= r_we ? IDLE : WAIT;
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        r_lu_valid  <= 1'b1;
                        r_lu_output <= w_ld_fmt;
                        r_lu_rd     <= r_rd;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_in_req       = (r_state == REQ);
    assign dmem_req_valid = w_in_req;
    assign dmem_we        = w_in_req & r_we;
    assign dmem_wstrb     = {4{w_in_req}} & r_wstrb;
    assign dmem_wdata     = {32{w_in_req}} & r_wdata;
    assign dmem_addr      = (r_state == IDLE) ? RESET_ADDR : r_addr;

    assign stall_out = w_start
                     | (w_in_req && !(r_we && dmem_req_ready))
                     | ((r_state == WAIT) && !dmem_rsp_valid);

    assign lu_valid_out   = r_lu_valid;
    assign lu_output_out  = r_lu_output;
    assign lu_rd_addr_out = r_lu_rd;
    assign misaligned_out = r_misal;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with hand-computed expected values.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        is_load_in;
    logic        is_store_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [4:0]  rd_addr_in;
    logic        stall_out;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        lu_valid_out;
    logic [31:0] lu_output_out;
    logic [4:0]  lu_rd_addr_out;
    logic        misaligned_out;

    int n_checks;
    int n_errors;
    int n_req;
    int req_base;

    mem_access_unit #(.ALIGN_CHECK(1'b1), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .is_load_in(is_load_in),
        .is_store_in(is_store_in), .addr_in(addr_in), .store_data_in(store_data_in),
        .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in), .rd_addr_in(rd_addr_in),
        .stall_out(stall_out), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .lu_valid_out(lu_valid_out),
        .lu_output_out(lu_output_out), .lu_rd_addr_out(lu_rd_addr_out), .misaligned_out(misaligned_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (dmem_req_valid && dmem_req_ready) n_req++;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, actual);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic uns, input logic [4:0] rd);
        valid_in = 1'b1; is_load_in = ld; is_store_in = st; addr_in = a;
        store_data_in = d; load_size_in = sz; load_unsigned_in = uns; rd_addr_in = rd;
    endtask

    task automatic idle_in();
        valid_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; n_req = 0;
        reset = 1'b1; idle_in(); addr_in = 32'h0; store_data_in = 32'h0;
        load_size_in = 2'b00; load_unsigned_in = 1'b0; rd_addr_in = 5'd0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
        tick(); tick();
        reset = 1'b0; #1;
        check("rst req_valid", {31'b0, dmem_req_valid}, 32'd0);
        check("rst stall", {31'b0, stall_out}, 32'd0);
        check("rst addr", dmem_addr, 32'h0);
        check("rst lu_valid", {31'b0, lu_valid_out}, 32'd0);
        check("rst lu_output", lu_output_out, 32'h0);

        // Load byte signed, minimum latency
        tick();
        present(1'b1, 1'b0, 32'h0000_1003, 32'h0, 2'b00, 1'b0, 5'd7);
        dmem_req_ready = 1'b1; #1;
        check("lb C0 stall", {31'b0, stall_out}, 32'd1);
        tick(); idle_in(); #1;
        check("lb C1 req_valid", {31'b0, dmem_req_valid}, 32'd1);
        check("lb C1 addr", dmem_addr, 32'h0000_1000);
        check("lb C1 we", {31'b0, dmem_we}, 32'd0);
        check("lb C1 wstrb", {28'b0, dmem_wstrb}, 32'h0);
        check("lb C1 stall", {31'b0, stall_out}, 32'd1);
        tick(); dmem_rsp_valid = 1'b1; dmem_rdata = 32'h8000_0000; #1;
        check("lb C2 req_valid", {31'b0, dmem_req_valid}, 32'd0);
        check("lb C2 stall", {31'b0, stall_out}, 32'd0);
        check("lb C2 lu_valid", {31'b0, lu_valid_out}, 32'd0);
        tick(); dmem_rsp_valid = 1'b0; #1;
        check("lb C3 lu_valid", {31'b0, lu_valid_out}, 32'd1);
        check("lb C3 lu_output", lu_output_out, 32'hFFFF_FF80);
        check("lb C3 rd", {27'b0, lu_rd_addr_out}, 32'd7);
        tick();
        check("lb C4 lu_valid", {31'b0, lu_valid_out}, 32'd0);

        // Stray response in IDLE is ignored
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'h1234_5678;
        tick(); dmem_rsp_valid = 1'b0; #1;
        check("stray rsp lu_valid", {31'b0, lu_valid_out}, 32'd0);

        // Load half unsigned, response two cycles after accept
        present(1'b1, 1'b0, 32'h0000_2002, 32'h0, 2'b01, 1'b1, 5'd3);
        tick(); idle_in();
        tick(); #1;
        check("lhu wait stall", {31'b0, stall_out}, 32'd1);
        tick(); dmem_rsp_valid = 1'b1; dmem_rdata = 32'hBEEF_1234;
        tick(); dmem_rsp_valid = 1'b0; #1;
        check("lhu lu_valid", {31'b0, lu_valid_out}, 32'd1);
        check("lhu lu_output", lu_output_out, 32'h0000_BEEF);

        // Store byte with ready low 3 cycles; a new op presented meanwhile must be ignored
        tick();
        dmem_req_ready = 1'b0;
        present(1'b0, 1'b1, 32'h0000_3001, 32'h0000_00A5, 2'b00, 1'b0, 5'd0);
        tick();
        present(1'b1, 1'b0, 32'h0000_7000, 32'h0, 2'b10, 1'b0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("sb hold%0d addr", i), dmem_addr, 32'h0000_3000);
            check($sformatf("sb hold%0d wstrb", i), {28'b0, dmem_wstrb}, 32'h2);
            check($sformatf("sb hold%0d wdata", i), dmem_wdata, 32'hA5A5_A5A5);
            check($sformatf("sb hold%0d we", i), {31'b0, dmem_we}, 32'd1);
            check($sformatf("sb hold%0d stall", i), {31'b0, stall_out}, 32'd1);
            tick();
        end
        dmem_req_ready = 1'b1; idle_in(); #1;
        check("sb accept stall", {31'b0, stall_out}, 32'd0);
        tick(); #1;
        check("sb after req_valid", {31'b0, dmem_req_valid}, 32'd0);
        check("sb after addr", dmem_addr, 32'h0);

        // Misaligned word load
        req_base = n_req;
        present(1'b1, 1'b0, 32'h0000_4002, 32'h0, 2'b10, 1'b0, 5'd1); #1;
        check("mis C0 stall", {31'b0, stall_out}, 32'd0);
        tick(); idle_in(); #1;
        check("mis C1 pulse", {31'b0, misaligned_out}, 32'd1);
        check("mis C1 req_valid", {31'b0, dmem_req_valid}, 32'd0);
        tick();
        check("mis C2 pulse", {31'b0, misaligned_out}, 32'd0);
        check("mis no request", n_req - req_base, 32'd0);

        // Reset in WAIT, then a late response
        present(1'b1, 1'b0, 32'h0000_6000, 32'h0, 2'b10, 1'b0, 5'd4);
        tick(); idle_in();
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
        check("rstw req_valid", {31'b0, dmem_req_valid}, 32'd0);
        check("rstw stall", {31'b0, stall_out}, 32'd0);
        check("rstw lu_output", lu_output_out, 32'h0);
        tick(); dmem_rsp_valid = 1'b0; #1;
        check("rstw lu_valid", {31'b0, lu_valid_out}, 32'd0);
        check("rstw lu_rd", {27'b0, lu_rd_addr_out}, 32'd0);

        // Store word then load half signed back-to-back
        req_base = n_req;
        present(1'b0, 1'b1, 32'h0000_5000, 32'h1122_3344, 2'b10, 1'b0, 5'd0);
        tick(); idle_in(); #1;
        check("b2b st wstrb", {28'b0, dmem_wstrb}, 32'hF);
        check("b2b st wdata", dmem_wdata, 32'h1122_3344);
        check("b2b st stall", {31'b0, stall_out}, 32'd0);
        tick();
        present(1'b1, 1'b0, 32'h0000_5006, 32'h0, 2'b01, 1'b0, 5'd12);
        tick(); idle_in(); #1;
        check("b2b ld addr", dmem_addr, 32'h0000_5004);
        tick(); dmem_rsp_valid = 1'b1; dmem_rdata = 32'h8001_7FFF;
        tick(); dmem_rsp_valid = 1'b0; #1;
        check("b2b ld lu_valid", {31'b0, lu_valid_out}, 32'd1);
        check("b2b ld lu_output", lu_output_out, 32'hFFFF_8001);
        check("b2b ld rd", {27'b0, lu_rd_addr_out}, 32'd12);
        check("b2b request count", n_req - req_base, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
